// File: rtl/data_mem_pkg.sv
// data_mem_pkg: MIPS load/store opcodes shared by the M-stage data memory.
package data_mem_pkg;
   typedef enum logic [5:0] {
      OP_LB  = 6'b100000,
      OP_LH  = 6'b100001,
      OP_LW  = 6'b100011,
      OP_LBU = 6'b100100,
      OP_LHU = 6'b100101,
      OP_SB  = 6'b101000,
      OP_SH  = 6'b101001,
      OP_SW  = 6'b101011
   } op_e;
endpackage

// File: rtl/data_mem_ext.sv
// dm_ext: combinational load lane extractor and sign/zero extender.
module dm_ext
   import data_mem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_lo,
   input  logic [5:0]  i_op,
   output logic [31:0] o_out
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   always_comb begin
      w_byte = 8'(i_word >> {i_lo, 3'b000});
      w_half = i_lo[1] ? i_word[31:16] : i_word[15:0];
      o_out  = i_op == OP_LW  ? i_word :
               i_op == OP_LB  ? {{24{w_byte[7]}}, w_byte} :
               i_op == OP_LBU ? {24'h0, w_byte} :
               i_op == OP_LH  ? {{16{w_half[15]}}, w_half} :
               i_op == OP_LHU ? {16'h0, w_half} : 32'h0;
   end
endmodule

// File: rtl/data_mem.sv
// data_mem: M-stage data RAM with byte-lane stores, extended loads and a write trace.
// Sub-word ops (lb/lbu/lh/lhu/sb/sh) are enabled by defining DM_SUBWORD_EN.
module data_mem
   import data_mem_pkg::*;
#(
   parameter int WORDS = 3072,
   parameter int AW    = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ir_M,
   input  logic [31:0] pc4_M,
   input  logic [31:0] ao_M,
   input  logic [31:0] rt_M,
   output logic [31:0] dm_out,
   output logic [3:0]  dm_be
);
   logic [31:0]   r_mem [WORDS];
   logic [5:0]    w_op;
   logic [AW-1:0] w_idx;
   logic          w_in_range;
   logic [31:0]   w_word;
   logic [31:0]   w_wdata;
   logic [31:0]   w_merged;
   logic          w_unused;
   assign w_op       = ir_M[31:26];
   assign w_idx      = ao_M[AW+1:2];
   assign w_in_range = ao_M < 32'(4 * WORDS);
   assign w_word     = w_in_range ? r_mem[w_idx] : 32'h0;
   assign w_unused   = ^ir_M[25:0];
`ifdef DM_SUBWORD_EN
   assign w_wdata = w_op == OP_SB ? {4{rt_M[7:0]}} :
                    w_op == OP_SH ? {2{rt_M[15:0]}} : rt_M;
   always_comb begin
      dm_be = 4'b0000;
      if (!reset && w_in_range)
         dm_be = w_op == OP_SW ? 4'b1111 :
                 w_op == OP_SH ? (ao_M[1] ? 4'b1100 : 4'b0011) :
                 w_op == OP_SB ? 4'b0001 << ao_M[1:0] : 4'b0000;
   end
   dm_ext u_ext (
      .i_word (w_word),
      .i_lo   (ao_M[1:0]),
      .i_op   (w_op),
      .o_out  (dm_out)
   );
`else
   assign w_wdata = rt_M;
   assign dm_be   = (!reset && w_in_range && w_op == OP_SW) ? 4'b1111 : 4'b0000;
   assign dm_out  = w_op == OP_LW ? w_word : 32'h0;
`endif
   always_comb begin
      w_merged = w_word;
      for (int i = 0; i < 4; i++)
         if (dm_be[i]) w_merged[8*i +: 8] = w_wdata[8*i +: 8];
   end
   // dm_be is already gated by reset, so a store in a reset cycle is neither written nor traced
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < WORDS; i++) r_mem[i] <= 32'h0;
      end else if (|dm_be) begin
         r_mem[w_idx] <= w_merged;
`ifndef SYNTHESIS
         $display("@%h: *%h <= %h", pc4_M - 32'd4, {ao_M[31:2], 2'b00}, w_merged);
`endif
      end
   end
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed plus random scoreboard bench for data_mem.
module tb_data_mem;
   localparam int WORDS = 3072;
   localparam logic [5:0] NOP = 6'b000000, LW = 6'b100011, LB = 6'b100000, LBU = 6'b100100,
                          LH = 6'b100001, LHU = 6'b100101, SW = 6'b101011, SB = 6'b101000,
                          SH = 6'b101001;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ir_M = '0, pc4_M = '0, ao_M = '0, rt_M = '0;
   logic [31:0] dm_out;
   logic [3:0]  dm_be;
   logic [31:0] mdl [WORDS];
   logic [35:0] sb_q [$];
   int          n_pass = 0, n_total = 0;
   logic [31:0] pc = 32'h0040_0000;

   data_mem dut (
      .clk    (clk),
      .reset  (reset),
      .ir_M   (ir_M),
      .pc4_M  (pc4_M),
      .ao_M   (ao_M),
      .rt_M   (rt_M),
      .dm_out (dm_out),
      .dm_be  (dm_be)
   );

   always #5 clk = ~clk;

   function automatic logic subword();
`ifdef DM_SUBWORD_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] a, input logic rst);
      if (rst || a >= 32'h3000) return 4'b0000;
      if (op == SW) return 4'b1111;
      if (!subword()) return 4'b0000;
      if (op == SH) return a[1] ? 4'b1100 : 4'b0011;
      if (op == SB) return 4'b0001 << a[1:0];
      return 4'b0000;
   endfunction

   function automatic logic [31:0] m_out(input logic [5:0] op, input logic [31:0] a);
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      if (a >= 32'h3000) return 32'h0;
      w = mdl[a[13:2]];
      case (a[1:0])
         2'd0: b = w[7:0];
         2'd1: b = w[15:8];
         2'd2: b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      if (op == LW) return w;
      if (!subword()) return 32'h0;
      if (op == LB)  return {{24{b[7]}}, b};
      if (op == LBU) return {24'h0, b};
      if (op == LH)  return {{16{h[15]}}, h};
      if (op == LHU) return {16'h0, h};
      return 32'h0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                       input logic rst);
      logic [3:0]  be;
      logic [35:0] e;
      @(negedge clk);
      reset = rst; ir_M = {op, 26'h0}; ao_M = a; rt_M = rt; pc4_M = pc + 32'd4;
      pc = pc + 32'd4;
      be = m_be(op, a, rst);
      sb_q.push_back({m_out(op, a), be});
      #1;
      e = sb_q.pop_front();
      chk($sformatf("be op=%b a=%h", op, a), {28'h0, dm_be}, {28'h0, e[3:0]});
      chk($sformatf("out op=%b a=%h", op, a), dm_out, e[35:4]);
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < WORDS; i++) mdl[i] = 32'h0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (be[i])
               mdl[a[13:2]][8*i +: 8] = op == SW ? rt[8*i +: 8] :
                                        op == SH ? rt[8*(i%2) +: 8] : rt[7:0];
      end
   endtask

   initial begin
      logic [5:0] ops [8];
      ops = '{LW, LB, LBU, LH, LHU, SW, SB, SH};
      step(SW, 32'h20, 32'hDEAD_BEEF, 1'b1);
      step(NOP, 32'h0, 32'h0, 1'b1);
      step(LW, 32'h10, 32'h0, 1'b0);
      chk("reset lw 0x10", dm_out, 32'h0);
      step(SW, 32'h10, 32'h1234_5678, 1'b0);
      step(LW, 32'h10, 32'h0, 1'b0);
      chk("lw after sw", dm_out, 32'h1234_5678);
      step(SB, 32'h13, 32'h0000_00AB, 1'b0);
      step(LB, 32'h13, 32'h0, 1'b0);
      chk("lb 0x13", dm_out, subword() ? 32'hFFFF_FFAB : 32'h0);
      step(LBU, 32'h13, 32'h0, 1'b0);
      chk("lbu 0x13", dm_out, subword() ? 32'h0000_00AB : 32'h0);
      step(LH, 32'h12, 32'h0, 1'b0);
      chk("lh 0x12", dm_out, subword() ? 32'hFFFF_AB34 : 32'h0);
      step(LHU, 32'h12, 32'h0, 1'b0);
      chk("lhu 0x12", dm_out, subword() ? 32'h0000_AB34 : 32'h0);
      step(LW, 32'h10, 32'h0, 1'b0);
      chk("lw after sb", dm_out, subword() ? 32'hAB34_5678 : 32'h1234_5678);
      step(SH, 32'h16, 32'h0000_BEEF, 1'b0);
      step(LW, 32'h14, 32'h0, 1'b0);
      chk("lw after sh", dm_out, subword() ? 32'hBEEF_0000 : 32'h0);
      step(SW, 32'h3000, 32'h5555_AAAA, 1'b0);
      step(LW, 32'h3000, 32'h0, 1'b0);
      step(LW, 32'h0, 32'h0, 1'b0);
      chk("oob sw aliasing word 0", dm_out, 32'h0);
      step(SW, 32'h2FFC, 32'hCAFE_F00D, 1'b0);
      step(LW, 32'h2FFC, 32'h0, 1'b0);
      chk("lw top word", dm_out, 32'hCAFE_F00D);
      step(SB, 32'h2FFF, 32'h0000_0011, 1'b0);
      step(LBU, 32'h2FFF, 32'h0, 1'b0);
      step(SW, 32'h20, 32'h7777_7777, 1'b1);
      step(LW, 32'h20, 32'h0, 1'b0);
      chk("lw after reset-cycle sw", dm_out, 32'h0);
      step(LW, 32'h10, 32'h0, 1'b0);
      chk("reset clears 0x10", dm_out, 32'h0);
      for (int i = 0; i < 60; i++)
         step(ops[$urandom_range(7)], {$urandom_range(31), $urandom_range(3)} & 32'h7F |
              ($urandom_range(9) == 0 ? 32'h2FC0 : 32'h0),
              $urandom, 1'b0);
      for (int i = 0; i < 16; i++)
         step(LW, 32'(i * 4), 32'h0, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
